bsg_chip_mem_link_adapter: RTL and testbench
============================================

BSG_CHIP_MEM_LINK_ADAPTER -- requirements
Module: bsg_chip_mem_link_adapter

Interface
REQ-001 SHALL have parameter msg_width_p, default cce_mem_msg_width_lp: width of one packed CCE memory message.
REQ-002 SHALL have parameter flit_width_p, default 64: off-chip link flit width; legal only if msg_width_p > flit_width_p.
REQ-003 SHALL define derived localparam N = ceil(msg_width_p / flit_width_p), the flits per message.
REQ-004 SHALL have port clk_i, input, 1: the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset_i, input, 1: synchronous active-high reset.
REQ-006 SHALL have port mem_cmd_i, input, msg_width_p: command from the core's mem_cmd_o.
REQ-007 SHALL have port mem_cmd_v_i, input, 1: command valid.
REQ-008 SHALL have port mem_cmd_ready_o, output, 1: command ready; ready/valid handshake.
REQ-009 SHALL have port link_data_o, output, flit_width_p: outbound flit.
REQ-010 SHALL have port link_v_o, output, 1: outbound flit valid.
REQ-011 SHALL have port link_ready_i, input, 1: link accepts the outbound flit.
REQ-012 SHALL have port link_data_i, input, flit_width_p: inbound flit.
REQ-013 SHALL have port link_v_i, input, 1: inbound flit valid.
REQ-014 SHALL have port link_ready_o, output, 1: adapter accepts the inbound flit.
REQ-015 SHALL have port mem_resp_o, output, msg_width_p: reassembled response to the core's mem_resp_i.
REQ-016 SHALL have port mem_resp_v_o, output, 1: response valid.
REQ-017 SHALL have port mem_resp_yumi_i, input, 1: response consumed; valid-then-yumi handshake.

Function
REQ-018 Tx FSM SHALL have states IDLE and SEND; mem_cmd_ready_o = 1 only in IDLE.
REQ-019 In IDLE, mem_cmd_v_i & mem_cmd_ready_o SHALL latch mem_cmd_i, clear tx count to 0, and go to SEND.
REQ-020 In SEND, link_v_o SHALL be 1 and link_data_o SHALL be latched message bits [cnt*flit_width_p +: flit_width_p].
REQ-021 The final flit SHALL be zero-padded above bit msg_width_p.
REQ-022 The tx count SHALL advance only when link_v_o & link_ready_i.
REQ-023 When flit N-1 is accepted, the tx count SHALL wrap to 0 and the FSM SHALL return to IDLE.
REQ-024 Command latency: a command accepted in cycle t SHALL put its first flit valid in cycle t+1; throughput is one message per N+1 cycles minimum.
REQ-025 link_data_o SHALL hold stable while link_v_o & ~link_ready_i.
REQ-026 Rx FSM SHALL have states COLLECT and FULL; link_ready_o = 1 only in COLLECT.
REQ-027 In COLLECT, each link_v_i & link_ready_o SHALL write the flit into slot rx_cnt and increment rx_cnt.
REQ-028 Accepting flit N-1 SHALL wrap rx_cnt to 0 and enter FULL.
REQ-029 Response latency: mem_resp_v_o SHALL be 1 in FULL, in cycle t+1 after the last flit is accepted in cycle t.
REQ-030 Padding bits of the last inbound flit SHALL be discarded; mem_resp_o = low msg_width_p bits of the collected flits.
REQ-031 In FULL, mem_resp_yumi_i SHALL return the FSM to COLLECT; a new first flit is accepted no earlier than the next cycle.
REQ-032 mem_resp_o SHALL hold stable while mem_resp_v_o & ~mem_resp_yumi_i.
REQ-033 Tx and Rx SHALL be fully independent; simultaneous activity on both paths SHALL not stall either path.
REQ-034 mem_resp_yumi_i asserted while mem_resp_v_o = 0 is illegal; an assertion SHALL flag it.

Reset
REQ-035 On reset_i: Tx SHALL go to IDLE, Rx to COLLECT, and both counters to 0.
REQ-036 During reset: mem_cmd_ready_o = 0, link_v_o = 0, link_ready_o = 0, mem_resp_v_o = 0; data registers need not reset.
REQ-037 Reset mid-message SHALL abandon any partial tx or rx message; no flit of it SHALL appear after reset.

Structure
REQ-038 flit_width_p default and the flit-count helper function SHALL live in bsg_chip_pkg.
REQ-039 The Tx path SHALL be a sub-module, bsg_chip_mem_link_tx, instantiated once; Rx stays inline.

Verification
REQ-040 Basic tx: msg_width_p = 600, flit 64 (N = 10); cmd = incrementing bytes, link_ready_i = 1 -> 10 flits on cycles t+1..t+10; flit 9 bits [63:24] = 0; ready_o returns in cycle t+11.
REQ-041 Tx backpressure: link_ready_i toggling 1010... -> flits unchanged and in order; ready_o low until flit 9 is accepted.
REQ-042 Rx reassembly: 10 flits with flit 9 upper bits = 1s -> mem_resp_o equals the original 600-bit message; v_o rises one cycle after flit 9.
REQ-043 Rx hold: yumi_i held 0 for 5 cycles -> link_ready_o = 0 and mem_resp_o stable; after yumi_i, link_ready_o = 1 the next cycle.
REQ-044 Reset mid-op: assert reset_i after tx flit 4 and rx flit 6 -> link_v_o = 0; the next rx message reassembles correctly from flit 0.
REQ-045 Concurrency: back-to-back cmds and resps simultaneously with random ready/yumi (1000 msgs) -> scoreboard matches, with no loss or duplication.

Source files
------------

// File: rtl/bsg_chip_pkg.sv
// Shared definitions for the chip memory link: default widths, flit-count helper and FSM state types.
package bsg_chip_pkg;

  localparam int flit_width_gp        = 64;
  localparam int cce_mem_msg_width_lp = 600;

  function automatic int flit_count(input int msg_width, input int flit_width);
    return (msg_width + flit_width - 1) / flit_width;
  endfunction

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_FULL    = 1'b1
  } rx_state_e;

endpackage

// File: rtl/bsg_chip_mem_link_tx.sv
// Outbound path: latches one CCE memory command and serializes it into flits, lowest slice first.
module bsg_chip_mem_link_tx
  import bsg_chip_pkg::*;
#(
  parameter int msg_width_p  = cce_mem_msg_width_lp,
  parameter int flit_width_p = flit_width_gp
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [msg_width_p-1:0]  mem_cmd_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_ready_o,
  output logic [flit_width_p-1:0] link_data_o,
  output logic                    link_v_o,
  input  logic                    link_ready_i
);

  localparam int n_flits_lp   = flit_count(msg_width_p, flit_width_p);
  localparam int cnt_width_lp = (n_flits_lp > 1) ? $clog2(n_flits_lp) : 1;
  localparam int pad_width_lp = n_flits_lp * flit_width_p;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(n_flits_lp - 1);

  tx_state_e                state_r, state_n;
  logic [cnt_width_lp-1:0]  cnt_r, cnt_n;
  logic [pad_width_lp-1:0]  msg_r, cmd_padded;
  logic                     cmd_fire;

  // Storing the message pre-padded makes the last flit's upper bits zero for free.
  always_comb begin
    cmd_padded                  = '0;
    cmd_padded[msg_width_p-1:0] = mem_cmd_i;
  end

  assign mem_cmd_ready_o = (state_r == TX_IDLE) & ~reset_i;
  assign link_v_o        = (state_r == TX_SEND) & ~reset_i;
  assign link_data_o     = msg_r[cnt_r*flit_width_p +: flit_width_p];

  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    cmd_fire = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (mem_cmd_v_i) begin
          cmd_fire = 1'b1;
          cnt_n    = '0;
          state_n  = TX_SEND;
        end
      end
      TX_SEND: begin
        if (link_ready_i) begin
          if (cnt_r == last_cnt_lp) begin
            cnt_n   = '0;
            state_n = TX_IDLE;
          end else begin
            cnt_n = cnt_r + 1'b1;
          end
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= TX_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_fire) msg_r <= cmd_padded;
  end

endmodule

// File: rtl/bsg_chip_mem_link_adapter.sv
// Bridges the core's packed CCE memory command/response messages onto a narrower flit link.
// Tx serializes in the sub-module; Rx reassembles inline and holds the response until yumi.
module bsg_chip_mem_link_adapter
  import bsg_chip_pkg::*;
#(
  parameter int msg_width_p  = cce_mem_msg_width_lp,
  parameter int flit_width_p = flit_width_gp
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [msg_width_p-1:0]  mem_cmd_i,
  input  logic                    mem_cmd_v_i,
  output logic                    mem_cmd_ready_o,
  output logic [flit_width_p-1:0] link_data_o,
  output logic                    link_v_o,
  input  logic                    link_ready_i,
  input  logic [flit_width_p-1:0] link_data_i,
  input  logic                    link_v_i,
  output logic                    link_ready_o,
  output logic [msg_width_p-1:0]  mem_resp_o,
  output logic                    mem_resp_v_o,
  input  logic                    mem_resp_yumi_i
);

  localparam int n_flits_lp   = flit_count(msg_width_p, flit_width_p);
  localparam int cnt_width_lp = (n_flits_lp > 1) ? $clog2(n_flits_lp) : 1;
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(n_flits_lp - 1);

  bsg_chip_mem_link_tx #(
    .msg_width_p (msg_width_p),
    .flit_width_p(flit_width_p)
  ) tx (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .mem_cmd_i      (mem_cmd_i),
    .mem_cmd_v_i    (mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o),
    .link_data_o    (link_data_o),
    .link_v_o       (link_v_o),
    .link_ready_i   (link_ready_i)
  );

  rx_state_e               rx_state_r, rx_state_n;
  logic [cnt_width_lp-1:0] rx_cnt_r, rx_cnt_n;
  logic [msg_width_p-1:0]  rx_buf_r;
  logic                    rx_fire;

  assign link_ready_o = (rx_state_r == RX_COLLECT) & ~reset_i;
  assign mem_resp_v_o = (rx_state_r == RX_FULL) & ~reset_i;
  assign mem_resp_o   = rx_buf_r;

  always_comb begin
    rx_state_n = rx_state_r;
    rx_cnt_n   = rx_cnt_r;
    rx_fire    = 1'b0;
    case (rx_state_r)
      RX_COLLECT: begin
        if (link_v_i) begin
          rx_fire = 1'b1;
          if (rx_cnt_r == last_cnt_lp) begin
            rx_cnt_n   = '0;
            rx_state_n = RX_FULL;
          end else begin
            rx_cnt_n = rx_cnt_r + 1'b1;
          end
        end
      end
      RX_FULL: begin
        if (mem_resp_yumi_i) rx_state_n = RX_COLLECT;
      end
      default: rx_state_n = RX_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_state_r <= RX_COLLECT;
      rx_cnt_r   <= '0;
    end else begin
      rx_state_r <= rx_state_n;
      rx_cnt_r   <= rx_cnt_n;
    end
  end

  // Per-bit slot select keeps the buffer exactly msg_width_p wide; padding of the last flit is dropped.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < msg_width_p; b++) begin
      if (rx_fire && (int'(rx_cnt_r) == b / flit_width_p))
        rx_buf_r[b] <= link_data_i[b % flit_width_p];
    end
  end

  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) mem_resp_yumi_i |-> mem_resp_v_o
  );

endmodule

// File: tb/tb_bsg_chip_mem_link_adapter.sv
// Bench for bsg_chip_mem_link_adapter: vector table for tx timing, directed rx/reset sequences,
// and a randomized concurrent run against a queue-based message/flit model.
module tb_bsg_chip_mem_link_adapter;

  localparam int MW        = 600;
  localparam int FW        = 64;
  localparam int N         = (MW + FW - 1) / FW;
  localparam int PW        = N * FW;
  localparam int LAST_BITS = MW - (N - 1) * FW;
  localparam int NMSG      = 1000;
  localparam int LIMIT     = 60000;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [MW-1:0] mem_cmd_i;
  logic          mem_cmd_v_i;
  logic          mem_cmd_ready_o;
  logic [FW-1:0] link_data_o;
  logic          link_v_o;
  logic          link_ready_i;
  logic [FW-1:0] link_data_i;
  logic          link_v_i;
  logic          link_ready_o;
  logic [MW-1:0] mem_resp_o;
  logic          mem_resp_v_o;
  logic          mem_resp_yumi_i;

  always #5 clk = ~clk;

  bsg_chip_mem_link_adapter #(.msg_width_p(MW), .flit_width_p(FW)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .mem_cmd_i      (mem_cmd_i),
    .mem_cmd_v_i    (mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o),
    .link_data_o    (link_data_o),
    .link_v_o       (link_v_o),
    .link_ready_i   (link_ready_i),
    .link_data_i    (link_data_i),
    .link_v_i       (link_v_i),
    .link_ready_o   (link_ready_o),
    .mem_resp_o     (mem_resp_o),
    .mem_resp_v_o   (mem_resp_v_o),
    .mem_resp_yumi_i(mem_resp_yumi_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] flit_of(input logic [MW-1:0] m, input int k);
    logic [PW-1:0] p;
    p         = '0;
    p[MW-1:0] = m;
    return p[k*FW +: FW];
  endfunction

  function automatic logic [FW-1:0] pad_junk(input logic [FW-1:0] f, input logic [FW-1:0] junk);
    logic [FW-1:0] hi;
    hi = '1;
    hi = hi << LAST_BITS;
    return (f & ~hi) | (junk & hi);
  endfunction

  function automatic logic [MW-1:0] rand_msg();
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
    return p[MW-1:0];
  endfunction

  typedef struct {
    bit            rst;
    bit            cmd_v;
    logic [MW-1:0] cmd;
    bit            lrdy;
    bit            exp_rdy;
    bit            exp_v;
    bit            chk_flit;
    logic [FW-1:0] exp_flit;
  } txvec_t;

  txvec_t tv[$];

  function automatic txvec_t mk(input bit rst, input bit cmd_v, input logic [MW-1:0] cmd, input bit lrdy,
                                input bit exp_rdy, input bit exp_v, input bit chk, input logic [FW-1:0] f);
    txvec_t v;
    v.rst = rst; v.cmd_v = cmd_v; v.cmd = cmd; v.lrdy = lrdy;
    v.exp_rdy = exp_rdy; v.exp_v = exp_v; v.chk_flit = chk; v.exp_flit = f;
    return v;
  endfunction

  // Sends one full inbound message, holds yumi off for hold cycles, then consumes it.
  task automatic rx_message(input logic [MW-1:0] m, input int hold, input string tag);
    logic [FW-1:0] ones;
    ones = '1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      link_v_i    = 1'b1;
      link_data_i = (k == N - 1) ? pad_junk(flit_of(m, k), ones) : flit_of(m, k);
      #1;
      check_bit({tag, "_ready_while_collect"}, link_ready_o, 1'b1);
      check_bit({tag, "_resp_v_early"}, mem_resp_v_o, 1'b0);
    end
    @(negedge clk);
    link_v_i = 1'b0;
    #1;
    check_bit({tag, "_resp_v_rise"}, mem_resp_v_o, 1'b1);
    check_bit({tag, "_ready_low_full"}, link_ready_o, 1'b0);
    check_vec({tag, "_resp_data"}, PW'(mem_resp_o), PW'(m));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      link_v_i    = 1'b1;
      link_data_i = 64'hdead_beef_0bad_f00d;
      #1;
      check_bit({tag, "_hold_v"}, mem_resp_v_o, 1'b1);
      check_bit({tag, "_hold_ready"}, link_ready_o, 1'b0);
      check_vec({tag, "_hold_data"}, PW'(mem_resp_o), PW'(m));
    end
    @(negedge clk);
    link_v_i        = 1'b0;
    mem_resp_yumi_i = 1'b1;
    #1;
    check_bit({tag, "_v_at_yumi"}, mem_resp_v_o, 1'b1);
    @(negedge clk);
    mem_resp_yumi_i = 1'b0;
    #1;
    check_bit({tag, "_v_after_yumi"}, mem_resp_v_o, 1'b0);
    check_bit({tag, "_ready_after_yumi"}, link_ready_o, 1'b1);
  endtask

  logic [MW-1:0] msg_a, msg_b, msg_c, msg_d, msg_e, msg_f;
  logic [FW-1:0] tx_exp_q[$];
  logic [MW-1:0] rx_exp_q[$];

  initial begin
    int k;
    int j;
    reset_i = 1'b1; mem_cmd_i = '0; mem_cmd_v_i = 1'b0; link_ready_i = 1'b0;
    link_data_i = '0; link_v_i = 1'b0; mem_resp_yumi_i = 1'b0;

    for (int i = 0; i < MW / 8; i++) begin
      msg_a[i*8 +: 8] = 8'(i);
      msg_b[i*8 +: 8] = 8'(i) ^ 8'ha5;
    end

    // Basic tx: accept at t, flits on t+1..t+10, ready again at t+11.
    tv.push_back(mk(1, 0, msg_a, 1, 0, 0, 0, '0));
    tv.push_back(mk(0, 1, msg_a, 1, 1, 0, 0, '0));
    for (int f = 0; f < N; f++) tv.push_back(mk(0, 0, msg_a, 1, 0, 1, 1, flit_of(msg_a, f)));
    tv.push_back(mk(0, 1, msg_b, 0, 1, 0, 0, '0));
    // Backpressure: ready toggles 0,1,0,1...; the same flit is held while stalled.
    k = 0; j = 0;
    while (k < N) begin
      tv.push_back(mk(0, 0, msg_b, (j % 2) == 1, 0, 1, 1, flit_of(msg_b, k)));
      if ((j % 2) == 1) k++;
      j++;
    end
    tv.push_back(mk(0, 0, msg_b, 0, 1, 0, 0, '0));

    repeat (2) @(negedge clk);
    #1;
    check_bit("reset_cmd_ready", mem_cmd_ready_o, 1'b0);
    check_bit("reset_link_v", link_v_o, 1'b0);
    check_bit("reset_link_ready", link_ready_o, 1'b0);
    check_bit("reset_resp_v", mem_resp_v_o, 1'b0);

    foreach (tv[i]) begin
      @(negedge clk);
      reset_i      = tv[i].rst;
      mem_cmd_v_i  = tv[i].cmd_v;
      mem_cmd_i    = tv[i].cmd;
      link_ready_i = tv[i].lrdy;
      #1;
      check_bit("tx_cmd_ready", mem_cmd_ready_o, tv[i].exp_rdy);
      check_bit("tx_link_v", link_v_o, tv[i].exp_v);
      if (tv[i].chk_flit) check_vec("tx_flit", PW'(link_data_o), PW'(tv[i].exp_flit));
    end

    // Rx reassembly with last-flit padding of ones and a 5-cycle yumi hold.
    msg_c = rand_msg();
    rx_message(msg_c, 5, "rx_basic");

    // Reset mid-op: tx flits 0..4 and rx flits 0..6 accepted, then reset.
    msg_d = rand_msg();
    msg_e = rand_msg();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      mem_cmd_v_i  = (c == 0);
      mem_cmd_i    = msg_d;
      link_ready_i = (c >= 1 && c <= 5);
      link_v_i     = 1'b1;
      link_data_i  = flit_of(msg_e, c);
      #1;
      check_bit("mid_rx_ready", link_ready_o, 1'b1);
      if (c == 0) check_bit("mid_cmd_ready", mem_cmd_ready_o, 1'b1);
      else check_vec("mid_tx_flit", PW'(link_data_o), PW'(flit_of(msg_d, c - 1)));
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset_i = 1'b1; mem_cmd_v_i = 1'b0; link_v_i = 1'b0; link_ready_i = 1'b1;
      #1;
      check_bit("rst_link_v", link_v_o, 1'b0);
      check_bit("rst_link_ready", link_ready_o, 1'b0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      reset_i = 1'b0;
      #1;
      check_bit("post_rst_link_v", link_v_o, 1'b0);
      check_bit("post_rst_cmd_ready", mem_cmd_ready_o, 1'b1);
      check_bit("post_rst_resp_v", mem_resp_v_o, 1'b0);
    end
    link_ready_i = 1'b0;
    msg_f = rand_msg();
    rx_message(msg_f, 1, "rx_after_reset");

    // Randomized concurrent run: both directions streaming with random ready/yumi.
    begin
      int cycles = 0, tx_sent = 0, flits_got = 0;
      int rx_sent = 0, rx_idx = 0, resp_got = 0;
      bit cmd_pending = 0, rx_busy = 0, flit_v = 0;
      logic [MW-1:0] cur_cmd, cur_rx;
      logic [FW-1:0] cur_flit;
      cur_cmd = '0; cur_rx = '0; cur_flit = '0;
      while ((flits_got < NMSG * N || resp_got < NMSG) && cycles < LIMIT) begin
        @(negedge clk);
        cycles++;
        if (!cmd_pending && tx_sent < NMSG && $urandom_range(3) != 0) begin
          cur_cmd     = rand_msg();
          cmd_pending = 1'b1;
        end
        mem_cmd_v_i = cmd_pending;
        mem_cmd_i   = cur_cmd;
        if (cmd_pending && mem_cmd_ready_o) begin
          for (int f = 0; f < N; f++) tx_exp_q.push_back(flit_of(cur_cmd, f));
          tx_sent++;
          cmd_pending = 1'b0;
        end

        link_ready_i = ($urandom_range(3) != 0);
        if (link_v_o) begin
          if (tx_exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rand_tx_extra_flit: got %0h expected no flit", link_data_o);
          end else begin
            check_vec("rand_tx_flit", PW'(link_data_o), PW'(tx_exp_q[0]));
            if (link_ready_i) begin
              void'(tx_exp_q.pop_front());
              flits_got++;
            end
          end
        end

        if (!rx_busy && rx_sent < NMSG) begin
          cur_rx  = rand_msg();
          rx_exp_q.push_back(cur_rx);
          rx_busy = 1'b1;
          rx_idx  = 0;
        end
        if (rx_busy && !flit_v && $urandom_range(3) != 0) begin
          flit_v   = 1'b1;
          cur_flit = flit_of(cur_rx, rx_idx);
          if (rx_idx == N - 1) cur_flit = pad_junk(cur_flit, FW'({$urandom, $urandom}));
        end
        link_v_i    = flit_v;
        link_data_i = cur_flit;
        if (flit_v && link_ready_o) begin
          flit_v = 1'b0;
          rx_idx++;
          if (rx_idx == N) begin
            rx_busy = 1'b0;
            rx_sent++;
          end
        end

        mem_resp_yumi_i = 1'b0;
        if (mem_resp_v_o) begin
          if (rx_exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rand_rx_extra_resp: got %0h expected no response", mem_resp_o);
          end else begin
            check_vec("rand_rx_resp", PW'(mem_resp_o), PW'(rx_exp_q[0]));
            if ($urandom_range(2) != 0) begin
              mem_resp_yumi_i = 1'b1;
              void'(rx_exp_q.pop_front());
              resp_got++;
            end
          end
        end
      end

      n_cmp++;
      if (cycles >= LIMIT) begin
        n_err++;
        $display("FAIL rand_timeout: got %0d flits %0d resps required %0d flits %0d resps",
                 flits_got, resp_got, NMSG * N, NMSG);
      end
      @(negedge clk);
      mem_cmd_v_i = 1'b0; link_v_i = 1'b0; link_ready_i = 1'b1; mem_resp_yumi_i = 1'b0;
      repeat (3) begin
        @(negedge clk);
        #1;
        check_bit("drain_link_v", link_v_o, 1'b0);
        check_bit("drain_resp_v", mem_resp_v_o, 1'b0);
      end
      check_vec("rand_flit_count", PW'(flits_got), PW'(NMSG * N));
      check_vec("rand_resp_count", PW'(resp_got), PW'(NMSG));
      check_vec("rand_tx_queue_left", PW'(tx_exp_q.size()), PW'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
